// File: rtl/ssd_mux_display.sv
// Time-multiplexed common-anode seven-segment driver with dwell/blank timing,
// hex decode, per-digit enables, leading-zero suppression and a tear-free double buffer.
module ssd_mux_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                      fast_clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     SSD_Anode_Activate,
    output logic [6:0]                SSD_LED_out,
    output logic                      frame_start
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;

    logic [TW-1:0]         tick_q, tick_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         active_q, active_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  fs_q, fs_d;

    logic                  tick_wrap;
    logic                  last_slot;
    logic                  in_window;
    logic                  upper_zero;
    logic                  suppressed;
    logic                  lit;
    logic [3:0]            cur_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        tick_wrap = (tick_q == TW'(REFRESH_DIV - 1));
        last_slot = (idx_q == IW'(NUM_DIGITS - 1));

        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        idx_d  = idx_q;
        if (tick_wrap) begin
            idx_d = last_slot ? '0 : idx_q + IW'(1);
        end

        shadow_d = load ? digits_in : shadow_q;
        // The displayed value only changes at the frame boundary, so a scan never mixes two values.
        active_d = active_q;
        if (tick_wrap && last_slot) begin
            active_d = load ? digits_in : shadow_q;
        end

        cur_nib    = active_q[{idx_q, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (active_q[4*j +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end

        // tick >= BLANK_CYCLES, written so BLANK_CYCLES = 0 is not a constant compare.
        in_window  = (({1'b0, tick_q} + (TW+1)'(1)) > (TW+1)'(BLANK_CYCLES));
        suppressed = lz_blank && (idx_q != '0) && upper_zero;
        lit        = in_window && digit_en[idx_q] && !suppressed;

        anode_d = '1;
        seg_d   = 7'b1111111;
        if (lit) begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = hex_to_seg(cur_nib);
        end

        fs_d = (tick_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            tick_q   <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            anode_q  <= '1;
            seg_q    <= 7'b1111111;
            fs_q     <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            anode_q  <= anode_d;
            seg_q    <= seg_d;
            fs_q     <= fs_d;
        end
    end

    assign SSD_Anode_Activate = anode_q;
    assign SSD_LED_out        = seg_q;
    assign frame_start        = fs_q;

endmodule
